// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 operation codes for the M extension
//   - md_state_t control states
//   - latency constants (edges from the start-sampling edge to done)
//   - helpers deciding which operands are treated as signed
// Optional build macro: MULDIV_FAST_MUL_EN (see muldiv_unit).
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } md_state_t;

  localparam int unsigned MD_ITER_LAT = 33;
  localparam int unsigned MD_FAST_LAT = 1;

  // rs1 is signed for MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is signed for MULH, DIV and REM.
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One radix-2 restoring-division step, purely combinational.
//   rem_in   partial remainder (always < divisor)
//   quo_in   dividend bits still to consume (MSB first) with quotient bits shifted in at LSB
//   divisor  unsigned divisor magnitude
//   rem_out  next partial remainder
//   quo_out  quo_in shifted left with the new quotient bit in the LSB
module muldiv_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    // Since rem_in < divisor, shifted < 2*divisor: a set MSB of diff means a borrow.
    if (diff[XLEN]) begin
      rem_out = shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end else begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Operands are latched as magnitudes on an accepted start, iterated unsigned one bit per cycle,
// and sign-corrected on the edge that enters DONE. Divide-by-zero and signed overflow take a
// fast path straight to DONE.
//   clk     clock
//   reset   synchronous, active-high
//   start   request; samples funct3, a, b (accepted in IDLE or DONE)
//   flush   aborts the operation in flight; wins over a simultaneous start
//   funct3  M-extension operation code
//   a, b    rs1 / rs2 operands
//   busy    high while iterating (MUL or DIV state)
//   done    one-cycle pulse, result valid
//   result  final value, held until the next completed operation
// Build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle 33x33 signed multiplier and
// complete on the start edge; the iterative shift-add path is not built.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  md_state_t         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;   // mul: {partial product, multiplier}; div: {rem, quo}
  logic [XLEN-1:0]   opb_q, opb_d;   // mul: multiplicand magnitude; div: divisor magnitude
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;   // final result must be negated
  logic [XLEN-1:0]   result_q, result_d;

  // Operand conditioning at start.
  logic            a_neg, b_neg, start_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, div_ovf;
  logic [XLEN-1:0] fast_div_res;

  always_comb begin
    a_neg = a_is_signed(funct3) & a[XLEN-1];
    b_neg = b_is_signed(funct3) & b[XLEN-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
    // Remainders follow the dividend; products and quotients follow the sign difference.
    start_neg = (funct3 == F3_REM || funct3 == F3_REMU) ? a_neg : (a_neg ^ b_neg);

    div_by_zero = (b == '0);
    div_ovf     = (funct3 == F3_DIV || funct3 == F3_REM) &&
                  (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    if (div_by_zero) begin
      fast_div_res = funct3[1] ? a : '1;
    end else begin
      fast_div_res = funct3[1] ? '0 : a;
    end
  end

  // Divide datapath: one restoring step per cycle.
  logic [XLEN-1:0] rem_next, quo_next, div_val, div_final;

  muldiv_div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_in (acc_q[2*XLEN-1:XLEN]),
    .quo_in (acc_q[XLEN-1:0]),
    .divisor(opb_q),
    .rem_out(rem_next),
    .quo_out(quo_next)
  );

  always_comb begin
    div_val   = op_q[1] ? rem_next : quo_next;
    div_final = neg_q ? (~div_val + 1'b1) : div_val;
  end

`ifdef MULDIV_FAST_MUL_EN
  // 33x33 signed multiply: the extra top bit sign- or zero-extends each operand per funct3.
  logic signed [2*XLEN+1:0] fm_prod;
  logic        [XLEN-1:0]   fast_mul_res;
  logic                     fm_unused;

  always_comb begin
    fm_prod = $signed({a_is_signed(funct3) & a[XLEN-1], a}) *
              $signed({b_is_signed(funct3) & b[XLEN-1], b});
    fast_mul_res = (funct3 == F3_MUL) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
    fm_unused    = ^fm_prod[2*XLEN+1:2*XLEN];
  end
`else
  // Shift-add multiply: add the multiplicand when the multiplier LSB is set, then shift the
  // whole {carry, high, low} accumulator right by one.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_prod;
  logic [XLEN-1:0]   mul_final;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    mul_prod  = neg_q ? (~mul_next + 1'b1) : mul_next;
    mul_final = (op_q == F3_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end
`endif

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            op_d  = funct3;
            neg_d = start_neg;
            cnt_d = '0;
            if (funct3[2]) begin
              if (div_by_zero || div_ovf) begin
                state_d  = DONE;
                result_d = fast_div_res;
              end else begin
                state_d = DIV;
                acc_d   = {{XLEN{1'b0}}, a_mag};
                opb_d   = b_mag;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              state_d  = DONE;
              result_d = fast_mul_res;
`else
              state_d = MUL;
              acc_d   = {{XLEN{1'b0}}, b_mag};
              opb_d   = a_mag;
`endif
            end
          end
        end
        MUL: begin
`ifdef MULDIV_FAST_MUL_EN
          state_d = IDLE;  // not reachable in this build
`else
          acc_d = mul_next;
          cnt_d = cnt_q + CW'(1);
          // The last step and the sign fix share the edge that enters DONE.
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d  = DONE;
            result_d = mul_final;
          end
`endif
        end
        DIV: begin
          acc_d = {rem_next, quo_next};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d  = DONE;
            result_d = div_final;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == MUL) || (state_q == DIV);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a vector table run through a scoreboard queue, plus
// hand-written sequences for reset, flush, ignored and back-to-back starts.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit #(
    .XLEN(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .flush (flush),
    .funct3(funct3),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          t0;
  } sb_t;

  vec_t        vecs[18];
  sb_t         sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call #1 after a clock edge; start is sampled on the next edge (edge 1 of the op).
  task automatic issue(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp, input int lat, input bit track);
    sb_t e;
    start  = 1'b1;
    funct3 = f;
    a      = av;
    b      = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (track) begin
      e.exp = exp;
      e.lat = lat;
      e.t0  = cyc;
      sb.push_back(e);
    end
  endtask

  // Wait (bounded) for done, then compare against the oldest scoreboard entry.
  task automatic collect(input string name);
    int  n;
    sb_t e;
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: done=%0d required=1", name, done);
    end
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s scoreboard: entries=0 required=1", name);
    end else begin
      e = sb.pop_front();
      check({name, " result"}, result, e.exp);
      check({name, " latency"}, 32'(cyc - e.t0 + 1), 32'(e.lat));
      check({name, " busy@done"}, {31'b0, busy}, 32'd0);
      last_res = e.exp;
    end
  endtask

  initial begin
    int dones;

    vecs[0]  = '{F3_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
    vecs[1]  = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
    vecs[2]  = '{F3_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000, MUL_LAT};
    vecs[3]  = '{F3_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
    vecs[4]  = '{F3_MULH,   32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, MUL_LAT};
    vecs[5]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
    vecs[6]  = '{F3_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT};
    vecs[7]  = '{F3_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT};
    vecs[8]  = '{F3_DIVU,   32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, DIV_LAT};
    vecs[9]  = '{F3_REMU,   32'hFFFFFFF9, 32'h00000002, 32'h00000001, DIV_LAT};
    vecs[10] = '{F3_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT};
    vecs[11] = '{F3_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, DIV_LAT};
    vecs[12] = '{F3_DIVU,   32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[13] = '{F3_REMU,   32'h12345678, 32'h00000000, 32'h12345678, 1};
    vecs[14] = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[15] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[16] = '{F3_DIV,    32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[17] = '{F3_REM,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);

    // Vector table.
    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].av, vecs[i].bv, vecs[i].exp, vecs[i].lat, 1'b1);
      collect($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
    end

    // Flush at edge 10 of a DIV: no done, busy low, result held; new start at edge 11.
    issue(F3_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 32'd0);
    check("flush done", {31'b0, done}, 32'd0);
    check("flush result held", result, last_res);
    issue(F3_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b1);
    collect("after flush");

    // Start in the DONE cycle launches a new op immediately.
    issue(F3_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT, 1'b1);
    collect("b2b first");
    issue(F3_MUL, 32'd6, 32'd7, 32'd42, MUL_LAT, 1'b1);
    collect("b2b second");
    @(posedge clk);
    #1;

    // Second start at edge 5 of a running DIV is ignored.
    issue(F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DIV_LAT, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start  = 1'b1;
    funct3 = F3_MUL;
    a      = 32'd3;
    b      = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    collect("ignored start");
    @(posedge clk);
    #1;

    // Flush and start together: start dropped.
    start  = 1'b1;
    flush  = 1'b1;
    funct3 = F3_DIVU;
    a      = 32'd9;
    b      = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush+start busy", {31'b0, busy}, 32'd0);
    check("flush+start done", {31'b0, done}, 32'd0);
    check("flush+start result", result, last_res);

    // Reset mid-operation: aborted, no done afterwards.
    issue(F3_DIV, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset busy", {31'b0, busy}, 32'd0);
    check("midreset result", result, 32'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("midreset no done", 32'(dones), 32'd0);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
